// File: rtl/conv_window_sched.sv
// Convolution window address scheduler: walks every stride-1 output position of a
// square map and emits the ksize x ksize input addresses of each window in raster order.
module conv_window_sched #(
  parameter int ADDR_W = 16,
  parameter int SIZE_W = 8,
  parameter int K_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  input  logic [K_W-1:0]    ksize,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              cfg_err,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              win_first,
  output logic              win_last,
  output logic [SIZE_W-1:0] out_row,
  output logic [SIZE_W-1:0] out_col,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              cfg_err_q, cfg_err_d;
  logic              done_q, done_d;
  logic [SIZE_W-1:0] or_q, or_d, oc_q, oc_d;
  logic [K_W-1:0]    kr_q, kr_d, kc_q, kc_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [K_W-1:0]    ksize_q, ksize_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [SIZE_W-1:0] span;
  logic              kc_last, kr_last, oc_last, or_last;
  logic              cfg_bad;
  logic [ADDR_W-1:0] row_idx, addr_raw;

  assign span    = size_q - SIZE_W'(ksize_q);
  assign kc_last = (kc_q == K_W'(ksize_q - K_W'(1)));
  assign kr_last = (kr_q == K_W'(ksize_q - K_W'(1)));
  assign oc_last = (oc_q == span);
  assign or_last = (or_q == span);
  assign cfg_bad = (ksize == '0) || (size == '0) || (SIZE_W'(ksize) > size);

  assign row_idx  = ADDR_W'(or_q) + ADDR_W'(kr_q);
  assign addr_raw = base_q + row_idx * ADDR_W'(size_q) + ADDR_W'(oc_q) + ADDR_W'(kc_q);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    cfg_err_d = 1'b0;
    done_d    = 1'b0;
    or_d      = or_q;
    oc_d      = oc_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    size_d    = size_q;
    ksize_d   = ksize_q;
    base_d    = base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            size_d  = size;
            ksize_d = ksize;
            base_d  = base_addr;
            or_d    = '0;
            oc_d    = '0;
            kr_d    = '0;
            kc_d    = '0;
            state_d = RUN;
            busy_d  = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid_q && addr_ready) begin
          // Odometer step: kc innermost, carry ripples out to or.
          kc_d = kc_last ? '0 : kc_q + K_W'(1);
          if (kc_last) begin
            kr_d = kr_last ? '0 : kr_q + K_W'(1);
            if (kr_last) begin
              oc_d = oc_last ? '0 : oc_q + SIZE_W'(1);
              if (oc_last) begin
                if (or_last) begin
                  or_d    = '0;
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                end else begin
                  or_d = or_q + SIZE_W'(1);
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
      or_q      <= '0;
      oc_q      <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      size_q    <= '0;
      ksize_q   <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      cfg_err_q <= cfg_err_d;
      done_q    <= done_d;
      or_q      <= or_d;
      oc_q      <= oc_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      size_q    <= size_d;
      ksize_q   <= ksize_d;
      base_q    <= base_d;
    end
  end

  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;
  assign done       = done_q;
  assign addr_valid = valid_q;
  assign addr       = valid_q ? addr_raw : '0;
  assign win_first  = valid_q && (kr_q == '0) && (kc_q == '0);
  assign win_last   = valid_q && kr_last && kc_last;
  assign out_row    = or_q;
  assign out_col    = oc_q;

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Scheduler that sequences feature-map address generation for one convolution pass.
- Given a square map of side `size` and a square kernel of side `ksize`, it walks every valid output position (stride 1, no padding). For each position it emits the ksize×ksize input addresses in raster order.
- Sits between the layer control FSM and the feature-map SRAM read port.
- Replaces the free-running counter as the address source for this pass.

Parameters:
- ADDR_W, 16, address width; all address arithmetic is modulo 2^ADDR_W.
- SIZE_W, 8, width of the map-side and output-coordinate fields.
- K_W, 4, width of the kernel-side field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a pass; accepted only in IDLE.
- size  in  SIZE_W  map side length; sampled when start is accepted.
- ksize  in  K_W  kernel side length; sampled when start is accepted.
- base_addr  in  ADDR_W  map base address; sampled when start is accepted.
- busy  out  1  high in RUN.
- cfg_err  out  1  one-cycle pulse when start is rejected for an illegal configuration.
- addr_valid  out  1  address available.
- addr_ready  in  1  consumer accepts the address.
- addr  out  ADDR_W  current input address.
- win_first  out  1  addr is the first element of its window.
- win_last  out  1  addr is the last element of its window.
- out_row  out  SIZE_W  output row of the current window.
- out_col  out  SIZE_W  output column of the current window.
- done  out  1  one-cycle pulse when the pass completes.

Behaviour:
- States: IDLE and RUN.
- Reset (rst=1 at a clk edge, including mid-pass):
  - state goes to IDLE.
  - All outputs are 0.
  - All internal counters and latched configuration are cleared.
  - Reset has priority over every other input.
- IDLE, start=1:
  - If ksize==0, size==0, or ksize>size: cfg_err=1 for one cycle; state stays IDLE.
  - Otherwise: latch size, ksize and base_addr; clear counters; go to RUN.
  - addr_valid rises on the cycle after start is accepted (one-cycle latency).
- RUN uses four counters, nested outermost to innermost: or (out_row), oc (out_col), kr, kc. Each counter runs from 0.
  - kc range: 0..ksize-1.
  - kr range: 0..ksize-1.
  - oc range: 0..size-ksize.
  - or range: 0..size-ksize.
- Address: addr = base_addr + (or+kr)*size + (oc+kc), truncated to ADDR_W; wrap-around is legal.
  - The multiply may be replaced by an incrementally maintained row base, but addr must be combinationally consistent with the registered counters.
- Flags:
  - win_first=1 iff kr==0 and kc==0.
  - win_last=1 iff kr==ksize-1 and kc==ksize-1.
  - out_row and out_col always equal or and oc.
- Handshake: a transfer occurs when addr_valid && addr_ready.
  - On a transfer, counters advance by one step.
  - Without a transfer, addr, the flags, out_row and out_col hold stable and addr_valid stays high; it never drops mid-pass.
- Last transfer (or==oc==size-ksize, kr==kc==ksize-1):
  - Next cycle: state is IDLE, addr_valid=0, busy=0, done=1 for exactly one cycle.
  - start may be accepted in that same done cycle.
- start while in RUN is ignored; the config inputs are not resampled.
- Total transfers per pass: (size-ksize+1)^2 × ksize^2.
- busy is registered: high from the cycle after start is accepted through the cycle of the last transfer.

Test Plan:
- size=4, ksize=3, base=0, addr_ready=1:
  - 36 transfers.
  - Window 0 addresses: 0,1,2,4,5,6,8,9,10.
  - Window 1 starts at 1 with out_col=1.
  - Window 3 ends at 15 with out_row=1, out_col=1.
  - done pulses one cycle after the 36th transfer.
- size=7, ksize=1, base=0x0100:
  - 49 transfers with addresses 0x0100..0x0130 in order.
  - win_first=win_last=1 on every transfer.
  - done one cycle after the last transfer.
- Illegal configuration: size=4, ksize=5, start=1 → cfg_err pulses once; addr_valid, busy and done stay 0. Repeat with ksize=0 → same result.
- Backpressure: size=4, ksize=2, addr_ready toggling pseudo-randomly → 36 transfers with the exact raster sequence. addr, win_first, win_last, out_row and out_col never change while valid && !ready.
- Wrap and ignored start:
  - base=0xFFFE, size=2, ksize=2 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - A start pulse with size=8 mid-pass is ignored.
- Reset mid-pass: size=7, ksize=3, assert rst for one cycle after 10 transfers →
  - Next cycle: all outputs 0, no done pulse.
  - A fresh start then restarts at window 0 with addr=base.
